// File: rtl/chrisruk_strip_decoder_if.sv
// Strip-decoder bundle: 2-wire strip input plus decoded pixel/frame outputs.
// master drives the strip lines (driver or bench); slave is the decoder.
interface chrisruk_strip_decoder_if #(
    parameter int IDX_W = 6
) ();
    logic             led_clk;
    logic             led_data;
    logic             pix_valid;
    logic [IDX_W-1:0] pix_idx;
    logic [4:0]       pix_bright;
    logic [23:0]      pix_data;
    logic             frame_done;
    logic             frame_err;
    logic [7:0]       frame_count;

    modport master (
        output led_clk, led_data,
        input  pix_valid, pix_idx, pix_bright, pix_data,
        input  frame_done, frame_err, frame_count
    );

    modport slave (
        input  led_clk, led_data,
        output pix_valid, pix_idx, pix_bright, pix_data,
        output frame_done, frame_err, frame_count
    );
endinterface

// File: rtl/chrisruk_strip_decoder.sv
// Decodes an APA102-style strip stream (32-bit zero start frame, 32-bit pixel words)
// back into per-pixel words and frame status pulses in the clk domain.
module chrisruk_strip_decoder #(
    parameter int NUM_LEDS = 64,
    parameter int IDX_W    = 6,
    parameter int TIMEOUT  = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    chrisruk_strip_decoder_if.slave bus
);
    localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [5:0]         RUN_FULL = 6'd32;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic {S_HUNT, S_PIXEL} state_t;

    // Two synchroniser flops per line plus one edge-detect stage; data uses the same
    // depth so the captured bit is the value seen during the last high sample of led_clk.
    logic [2:0]       r_clk_sync;
    logic [2:0]       r_dat_sync;
    logic             w_bit_stb;
    logic             w_bit;

    state_t           r_state,       w_state;
    logic [5:0]       r_run,         w_run;
    logic [4:0]       r_bitcnt,      w_bitcnt;
    logic [31:0]      r_shift,       w_shift;
    logic [IDX_W-1:0] r_target,      w_target;
    logic [TMO_W-1:0] r_tmo,         w_tmo;
    logic             r_pix_valid,   w_pix_valid;
    logic [IDX_W-1:0] r_pix_idx,     w_pix_idx;
    logic [4:0]       r_pix_bright,  w_pix_bright;
    logic [23:0]      r_pix_data,    w_pix_data;
    logic             r_frame_done,  w_frame_done;
    logic             r_frame_err,   w_frame_err;
    logic [7:0]       r_frame_count, w_frame_count;
    logic [31:0]      w_word;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], bus.led_clk};
            r_dat_sync <= {r_dat_sync[1:0], bus.led_data};
        end
    end

    assign w_bit_stb = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit     = r_dat_sync[2];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state       = r_state;
        w_run         = r_run;
        w_bitcnt      = r_bitcnt;
        w_shift       = r_shift;
        w_target      = r_target;
        w_tmo         = r_tmo;
        w_pix_valid   = 1'b0;
        w_pix_idx     = r_pix_idx;
        w_pix_bright  = r_pix_bright;
        w_pix_data    = r_pix_data;
        w_frame_done  = 1'b0;
        w_frame_err   = 1'b0;
        w_frame_count = r_frame_count;
        w_word        = {r_shift[30:0], w_bit};

        case (r_state)
            S_HUNT: begin
                w_tmo = '0;
                if (w_bit_stb) begin
                    if (!w_bit) begin
                        if (r_run != RUN_FULL) w_run = r_run + 6'd1;
                    end else if (r_run == RUN_FULL) begin
                        // This '1' is the MSB of pixel 0's header.
                        w_state  = S_PIXEL;
                        w_run    = '0;
                        w_bitcnt = 5'd1;
                        w_shift  = 32'd1;
                        w_target = '0;
                    end else begin
                        w_run = '0;
                    end
                end
            end

            S_PIXEL: begin
                if (w_bit_stb) begin
                    w_tmo    = '0;
                    w_shift  = w_word;
                    w_bitcnt = r_bitcnt + 5'd1;
                    if (r_bitcnt == 5'd31) begin
                        if (w_word[31:29] == 3'b111) begin
                            w_pix_valid  = 1'b1;
                            w_pix_idx    = r_target;
                            w_pix_bright = w_word[28:24];
                            w_pix_data   = w_word[23:0];
                            if (r_target == LAST_IDX) begin
                                w_frame_done  = 1'b1;
                                w_frame_count = r_frame_count + 8'd1;
                                w_state       = S_HUNT;
                                w_run         = '0;
                            end else begin
                                w_target = r_target + IDX_W'(1);
                            end
                        end else if (w_word == '0) begin
                            // A zero word ends a short frame and doubles as the next start frame.
                            w_frame_done = 1'b1;
                            w_frame_err  = 1'b1;
                            w_state      = S_HUNT;
                            w_run        = RUN_FULL;
                        end else begin
                            w_frame_done = 1'b1;
                            w_frame_err  = 1'b1;
                            w_state      = S_HUNT;
                            w_run        = '0;
                        end
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_frame_done = 1'b1;
                    w_frame_err  = 1'b1;
                    w_state      = S_HUNT;
                    w_run        = '0;
                    w_tmo        = '0;
                end else begin
                    w_tmo = r_tmo + TMO_W'(1);
                end
            end

            default: w_state = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_HUNT;
            r_run         <= '0;
            r_bitcnt      <= '0;
            r_shift       <= '0;
            r_target      <= '0;
            r_tmo         <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_idx     <= '0;
            r_pix_bright  <= '0;
            r_pix_data    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state;
            r_run         <= w_run;
            r_bitcnt      <= w_bitcnt;
            r_shift       <= w_shift;
            r_target      <= w_target;
            r_tmo         <= w_tmo;
            r_pix_valid   <= w_pix_valid;
            r_pix_idx     <= w_pix_idx;
            r_pix_bright  <= w_pix_bright;
            r_pix_data    <= w_pix_data;
            r_frame_done  <= w_frame_done;
            r_frame_err   <= w_frame_err;
            r_frame_count <= w_frame_count;
        end
    end

    assign bus.pix_valid   = r_pix_valid;
    assign bus.pix_idx     = r_pix_idx;
    assign bus.pix_bright  = r_pix_bright;
    assign bus.pix_data    = r_pix_data;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_err   = r_frame_err;
    assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_chrisruk_strip_decoder.sv
// Directed bench for chrisruk_strip_decoder: drives strip frames bit by bit and
// compares the recorded pixel/frame pulses against hand-computed expectations.
module tb_chrisruk_strip_decoder;
    localparam int NUM_LEDS = 64;
    localparam int IDX_W    = 6;
    localparam int TIMEOUT  = 4096;
    localparam logic [31:0] GOOD_W  = 32'hF00F_0000;
    localparam logic [31:0] BLACK_W = 32'hF000_0000;

    typedef struct packed {
        logic [5:0]  idx;
        logic [4:0]  bright;
        logic [23:0] data;
    } pix_t;

    typedef struct packed {
        logic err;
        logic with_pix;
    } done_t;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  bright;
        logic [23:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_count = 0;
    pix_t  pix_q[$];
    done_t done_q[$];
    vec_t  vecs[8];

    chrisruk_strip_decoder_if #(.IDX_W(IDX_W)) bus ();

    chrisruk_strip_decoder #(
        .NUM_LEDS(NUM_LEDS),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Record pulses on the falling clk edge, away from the DUT's update edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.pix_valid) pix_q.push_back('{bus.pix_idx, bus.pix_bright, bus.pix_data});
            if (bus.frame_done) done_q.push_back('{bus.frame_err, bus.pix_valid});
            if (bus.frame_err) check("err_without_done", 64'(bus.frame_done), 64'd1);
            if (bus.pix_valid && bus.frame_done) check("err_with_pix", 64'(bus.frame_err), 64'd0);
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.led_data = b;
        bus.led_clk  = 1'b1;
        @(negedge clk);
        bus.led_clk  = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        pix_q.delete();
        done_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {bus.pix_valid, bus.pix_idx, bus.pix_bright, bus.pix_data,
                     bus.frame_done, bus.frame_err, bus.frame_count}, 64'd0);
    endtask

    // Expect one done pulse at position i with the given error/coincident-pixel flags.
    task automatic check_done(input string name, input int i, input logic err, input logic with_pix);
        if (done_q.size() > i) check(name, 64'(done_q[i]), 64'({err, with_pix}));
        else check({name, "_missing"}, 64'(done_q.size()), 64'(i + 1));
    endtask

    task automatic check_pix(input string name, input int i, input pix_t exp);
        if (pix_q.size() > i) check(name, 64'(pix_q[i]), 64'(exp));
        else check({name, "_missing"}, 64'(pix_q.size()), 64'(i + 1));
    endtask

    task automatic good_frame_checked(input string tag);
        clear_q();
        send_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) send_bits(GOOD_W, 32);
        send_zeros(64);
        exp_count++;
        check({tag, "_npix"}, 64'(pix_q.size()), 64'(NUM_LEDS));
        for (int i = 0; i < NUM_LEDS; i++) check_pix({tag, "_pix"}, i, '{6'(i), 5'd16, 24'h0F0000});
        check({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
        check_done({tag, "_done"}, 0, 1'b0, 1'b1);
        check({tag, "_count"}, 64'(bus.frame_count), 64'(exp_count));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hF00F_0000, 5'd16, 24'h0F0000};
        vecs[1] = '{32'hFF12_3456, 5'd31, 24'h123456};
        vecs[2] = '{32'hE0AB_CDEF, 5'd0,  24'hABCDEF};
        vecs[3] = '{32'hE100_0001, 5'd1,  24'h000001};
        vecs[4] = '{32'hF000_0000, 5'd16, 24'h000000};
        vecs[5] = '{32'hEAFF_FFFF, 5'd10, 24'hFFFFFF};
        vecs[6] = '{32'hF580_0000, 5'd21, 24'h800000};
        vecs[7] = '{32'hE75A_5AA5, 5'd7,  24'h5A5AA5};

        // Reset held with toggling strip lines.
        bus.led_clk  = 1'b0;
        bus.led_data = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.led_clk  = ~bus.led_clk;
            bus.led_data = 1'(i >> 1);
            check_outputs_zero("reset_hold");
        end
        bus.led_clk  = 1'b0;
        bus.led_data = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(100);
        check("idle_no_pix", 64'(pix_q.size()), 64'd0);
        check("idle_no_done", 64'(done_q.size()), 64'd0);
        check("idle_count", 64'(bus.frame_count), 64'd0);

        good_frame_checked("good");

        // Two alternating colours.
        clear_q();
        send_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) send_bits((i % 2 == 0) ? GOOD_W : BLACK_W, 32);
        send_zeros(64);
        exp_count++;
        check("alt_npix", 64'(pix_q.size()), 64'(NUM_LEDS));
        for (int i = 0; i < NUM_LEDS; i++)
            check_pix("alt_pix", i, '{6'(i), 5'd16, (i % 2 == 0) ? 24'h0F0000 : 24'h000000});
        check_done("alt_done", 0, 1'b0, 1'b1);
        check("alt_count", 64'(bus.frame_count), 64'(exp_count));

        // Table-driven pixel words across a full frame.
        clear_q();
        send_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) send_bits(vecs[i % 8].word, 32);
        send_zeros(64);
        exp_count++;
        check("tbl_npix", 64'(pix_q.size()), 64'(NUM_LEDS));
        for (int i = 0; i < NUM_LEDS; i++)
            check_pix("tbl_pix", i, '{6'(i), vecs[i % 8].bright, vecs[i % 8].data});
        check_done("tbl_done", 0, 1'b0, 1'b1);
        check("tbl_count", 64'(bus.frame_count), 64'(exp_count));

        // Bad header on pixel 5, rest of the frame still streamed.
        clear_q();
        send_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) send_bits((i == 5) ? 32'h7000_0000 : GOOD_W, 32);
        send_zeros(64);
        check("bad_npix", 64'(pix_q.size()), 64'd5);
        check("bad_ndone", 64'(done_q.size()), 64'd1);
        check_done("bad_done", 0, 1'b1, 1'b0);
        check("bad_count", 64'(bus.frame_count), 64'(exp_count));
        good_frame_checked("after_bad");

        // Short frame: 10 pixels, a zero word acting as the next start, then a full frame.
        clear_q();
        send_zeros(32);
        for (int i = 0; i < 10; i++) send_bits(GOOD_W, 32);
        send_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) send_bits(GOOD_W, 32);
        send_zeros(64);
        exp_count++;
        check("short_npix", 64'(pix_q.size()), 64'(10 + NUM_LEDS));
        for (int i = 0; i < 10; i++) check_pix("short_pix", i, '{6'(i), 5'd16, 24'h0F0000});
        for (int i = 0; i < NUM_LEDS; i++) check_pix("short_full_pix", 10 + i, '{6'(i), 5'd16, 24'h0F0000});
        check("short_ndone", 64'(done_q.size()), 64'd2);
        check_done("short_err", 0, 1'b1, 1'b0);
        check_done("short_ok", 1, 1'b0, 1'b1);
        check("short_count", 64'(bus.frame_count), 64'(exp_count));

        // Strip clock stalls mid-pixel.
        clear_q();
        send_zeros(32);
        for (int i = 0; i < 3; i++) send_bits(GOOD_W, 32);
        send_bits(GOOD_W, 10);
        idle(TIMEOUT - 100);
        check("tmo_early", 64'(done_q.size()), 64'd0);
        idle(200);
        check("tmo_npix", 64'(pix_q.size()), 64'd3);
        check("tmo_ndone", 64'(done_q.size()), 64'd1);
        check_done("tmo_done", 0, 1'b1, 1'b0);
        check("tmo_count", 64'(bus.frame_count), 64'(exp_count));

        // Asynchronous reset in the middle of a word.
        clear_q();
        send_zeros(32);
        for (int i = 0; i < 2; i++) send_bits(GOOD_W, 32);
        send_bits(GOOD_W, 16);
        check("pre_rst_idx", 64'(bus.pix_idx), 64'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        idle(3);
        reset_n = 1'b1;
        exp_count = 0;
        clear_q();
        send_zeros(16);
        for (int i = 0; i < 3; i++) send_bits(GOOD_W, 32);
        idle(10);
        check("rst_no_pix", 64'(pix_q.size()), 64'd0);
        check("rst_no_done", 64'(done_q.size()), 64'd0);
        good_frame_checked("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
